pixel_fetch: RTL

- Reads one frame of pixels from a synchronous-read pixel memory in raster order.
- Absorbs the memory read latency in a credit-controlled FIFO and presents the pixels as a valid/ready stream, with frame-start and line-end markers, to the HDMI output path.
- Successor to the fixed 24-bit single-state pixel writer; frame size, pixel width, memory latency, buffer depth and base address are parametrised.
- Adds single-shot and continuous (frame-repeat) modes.

---
 rtl/pixel_fetch.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/pixel_fetch.sv
// Raster-order frame reader: issues pixel-memory reads under a credit limit and buffers the
// returning data in a show-ahead FIFO presented as a valid/ready stream with frame/line markers.
module pixel_fetch #(
  parameter int unsigned           DATA_WIDTH = 24,
  parameter int unsigned           H_ACTIVE   = 640,
  parameter int unsigned           V_ACTIVE   = 480,
  parameter int unsigned           ADDR_WIDTH = 19,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int unsigned           RD_LATENCY = 2,
  parameter int unsigned           FIFO_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  start,
  input  logic                  continuous,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic                  memRead,
  input  logic [DATA_WIDTH-1:0] memData,
  output logic [DATA_WIDTH-1:0] dataOutput,
  output logic                  dataValid,
  input  logic                  dataReady,
  output logic                  frameStart,
  output logic                  lineEnd,
  output logic                  frameDone
);

  localparam int unsigned XW = $clog2(H_ACTIVE);
  localparam int unsigned YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned EW = DATA_WIDTH + 2;
  localparam logic [XW-1:0] XLast = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] YLast = YW'(V_ACTIVE - 1);
  localparam logic [CW:0]   Depth = (CW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  state_e                state_q, state_d;
  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_read_q, mem_read_d;
  logic [1:0]            tag_q, tag_d;
  logic [2:0]            sr_q [RD_LATENCY];
  logic [2:0]            sr_d [RD_LATENCY];
  logic [CW-1:0]         inflight_q, inflight_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [EW-1:0]         fifo_q [FIFO_DEPTH];
  logic [EW-1:0]         fifo_d [FIFO_DEPTH];
  logic                  frame_done_q, frame_done_d;

  logic          push, pop, empty, credit_ok, last_pop;
  logic [CW:0]   occupancy;
  logic [EW-1:0] head;

  assign push      = sr_q[RD_LATENCY-1][2];
  assign empty     = (cnt_q == '0);
  assign pop       = !empty && dataReady;
  assign occupancy = {1'b0, cnt_q} + {1'b0, inflight_q};
  // A slot freed by this cycle's pop is reusable now; keeps one pixel per cycle at depth L+2.
  assign credit_ok = occupancy < (Depth + {{CW{1'b0}}, pop});
  assign last_pop  = pop && (cnt_q == CW'(1)) && (inflight_q == '0);

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    addr_d       = addr_q;
    mem_addr_d   = mem_addr_q;
    mem_read_d   = 1'b0;
    tag_d        = 2'b00;
    frame_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        x_d        = '0;
        y_d        = '0;
        addr_d     = BASE_ADDR;
        mem_addr_d = BASE_ADDR;
        if (start) state_d = StFetch;
      end
      StFetch: begin
        if (credit_ok) begin
          mem_read_d = 1'b1;
          mem_addr_d = addr_q;
          tag_d      = {(x_q == '0) && (y_q == '0), x_q == XLast};
          addr_d     = addr_q + ADDR_WIDTH'(1);
          if (x_q == XLast) begin
            x_d = '0;
            if (y_q == YLast) state_d = StDrain;
            else              y_d = y_q + YW'(1);
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      StDrain: begin
        x_d    = '0;
        y_d    = '0;
        addr_d = BASE_ADDR;
        if (last_pop) begin
          frame_done_d = 1'b1;
          state_d      = continuous ? StFetch : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    sr_d[0] = {mem_read_q, tag_q};
    for (int unsigned i = 1; i < RD_LATENCY; i++) sr_d[i] = sr_q[i-1];

    inflight_d = inflight_q;
    unique case ({mem_read_d, push})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase

    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      fifo_d[wr_ptr_q] = {memData, sr_q[RD_LATENCY-1][1:0]};
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q      <= StIdle;
      x_q          <= '0;
      y_q          <= '0;
      addr_q       <= BASE_ADDR;
      mem_addr_q   <= BASE_ADDR;
      mem_read_q   <= 1'b0;
      tag_q        <= 2'b00;
      inflight_q   <= '0;
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      frame_done_q <= 1'b0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) sr_q[i] <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      addr_q       <= addr_d;
      mem_addr_q   <= mem_addr_d;
      mem_read_q   <= mem_read_d;
      tag_q        <= tag_d;
      inflight_q   <= inflight_d;
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      frame_done_q <= frame_done_d;
      for (int unsigned i = 0; i < RD_LATENCY; i++) sr_q[i] <= sr_d[i];
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= fifo_d[i];
    end
  end

  assign head       = fifo_q[rd_ptr_q];
  assign busy       = (state_q != StIdle);
  assign memAddr    = mem_addr_q;
  assign memRead    = mem_read_q;
  assign dataOutput = head[EW-1:2];
  assign frameStart = head[1];
  assign lineEnd    = head[0];
  assign dataValid  = !empty;
  assign frameDone  = frame_done_q;

endmodule
